// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_pkg
//  Brief    : Shared types and constants for the fetch sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    REDIRECT = 2'd2,
    HALTED   = 2'd3
  } pc_state_t;

  localparam logic [31:0] PC_RESET_VEC = 32'h0000_09F0;
  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] BR_BIAS      = 32'd4;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_next_calc.sv
`default_nettype none
// ============================================================================
//  Module   : pc_next_calc
//  Brief    : Combinational next-PC selection, adders and alignment check.
//             Macro PC_MISALIGN_TRAP_EN turns misaligned targets into a trap.
//  Revision : 1.0  initial release
// ============================================================================
module pc_next_calc
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = PC_RESET_VEC
) (
  input  logic [31:0] pc,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        br_taken,
  input  logic [31:0] br_offset,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] seq_pc,
  output logic        trap
);

  logic [31:0] w_raw_target;

  // Jump wins over a taken branch in the same cycle.
  assign w_raw_target = jmp ? (jmp_target + RESET_VEC)
                            : (pc + br_offset - BR_BIAS);
  assign redirect     = jmp | br_taken;
  assign seq_pc       = pc + PC_STEP;

`ifdef PC_MISALIGN_TRAP_EN
  assign redirect_pc  = w_raw_target;
  assign trap         = is_misaligned(w_raw_target);
`else
  assign redirect_pc  = w_raw_target & ~32'd3;
  assign trap         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/pc_fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_seq
//  Brief    : PC owner and instruction-fetch handshake sequencer with one-cycle
//             flush after redirects. Optional macro: PC_MISALIGN_TRAP_EN.
//  Revision : 1.0  initial release
// ============================================================================
module pc_fetch_seq
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = PC_RESET_VEC,
  parameter int          CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             stall_i,
  input  logic             jmp_i,
  input  logic [31:0]      jmp_target_i,
  input  logic             br_i,
  input  logic             zero_i,
  input  logic [31:0]      br_offset_i,
  input  logic             halt_i,
  input  logic             imem_ack_i,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  output logic [31:0]      pc_o,
  output logic             fetch_valid_o,
  output logic             flush_o,
  output logic             halted_o,
  output logic             err_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  pc_state_t        r_state, w_state_nxt;
  logic [31:0]      r_pc, w_pc_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_inc;
  logic             w_redirect, w_trap;
  logic [31:0]      w_redirect_pc, w_seq_pc;

  pc_next_calc #(.RESET_VEC(RESET_VEC)) u_next (
    .pc          (r_pc),
    .jmp         (jmp_i),
    .jmp_target  (jmp_target_i),
    .br_taken    (br_i & ~zero_i),
    .br_offset   (br_offset_i),
    .redirect    (w_redirect),
    .redirect_pc (w_redirect_pc),
    .seq_pc      (w_seq_pc),
    .trap        (w_trap)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_VEC;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_cnt_inc && !(&r_cnt))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_cnt_inc     = 1'b0;
    imem_req_o    = 1'b0;
    flush_o       = 1'b0;
    halted_o      = 1'b0;
    fetch_valid_o = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = FETCH;
      FETCH: begin
        imem_req_o = 1'b1;
        if (halt_i) begin
          w_state_nxt = HALTED;
        end else if (w_redirect) begin
          // Any ack arriving with a redirect is wrong-path and dropped.
          if (w_trap) begin
            w_state_nxt = HALTED;
          end else begin
            w_pc_nxt    = w_redirect_pc;
            w_state_nxt = REDIRECT;
            w_cnt_inc   = 1'b1;
          end
        end else if (imem_ack_i && !stall_i) begin
          w_pc_nxt      = w_seq_pc;
          fetch_valid_o = 1'b1;
        end
      end
      REDIRECT: begin
        flush_o     = 1'b1;
        w_state_nxt = FETCH;
      end
      HALTED: halted_o = 1'b1;
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic r_err;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      r_err <= 1'b0;
    else if (r_state == FETCH && !halt_i && w_redirect && w_trap)
      r_err <= 1'b1;
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  assign pc_o           = r_pc;
  assign imem_addr_o    = r_pc;
  assign redirect_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: doc/pc_fetch_seq.md
Name: pc_fetch_seq

Overview:
Fetch sequencer that owns the program counter and drives the instruction-memory request handshake. It arbitrates between sequential fetch, jumps and taken branches, and inserts one flush bubble after every redirect. It halts on request. It sits between the control unit (jump/branch/zero/stall/halt) and instruction memory, and replaces the free-running PC register.

Parameters:
RESET_VEC, 32'h9F0, reset PC; also the base added to absolute jump targets
CNT_W, 16, width of the saturating redirect counter

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
stall_i  in  1  downstream hazard; hold PC, do not accept the fetch
jmp_i  in  1  jump request
jmp_target_i  in  32  jump target, relative to RESET_VEC
br_i  in  1  branch instruction in resolve stage
zero_i  in  1  ALU zero flag; branch is taken when br_i && !zero_i
br_offset_i  in  32  signed byte offset, applied as pc + offset - 4
halt_i  in  1  stop fetching; sticky until reset
imem_ack_i  in  1  instruction memory accepts or returns this cycle
imem_req_o  out  1  fetch request
imem_addr_o  out  32  fetch address, always equal to pc_o
pc_o  out  32  current PC
fetch_valid_o  out  1  instruction at pc_o accepted this cycle
flush_o  out  1  kill the wrong-path instruction in the fetch/decode latch
halted_o  out  1  high in HALTED
err_o  out  1  misaligned-target error (tied 0 without the macro)
redirect_cnt_o  out  CNT_W  count of taken redirects, saturating

Behaviour:
- Reset, asynchronous, any state: state=IDLE, pc_o=RESET_VEC, and every other output = 0, including redirect_cnt_o.
- States: IDLE, FETCH, REDIRECT, HALTED.
- IDLE: imem_req_o=0. Unconditionally goes to FETCH on the next edge.
- FETCH: imem_req_o=1. Priority order, evaluated each cycle:
  1. halt_i → HALTED; pc_o holds.
  2. jmp_i → pc_o = jmp_target_i + RESET_VEC, state goes to REDIRECT.
  3. br_i && !zero_i → pc_o = pc_o + br_offset_i - 4 (signed, modulo 2^32), state goes to REDIRECT.
  4. imem_ack_i && !stall_i → pc_o += 4; state stays FETCH.
  5. Otherwise hold.
- fetch_valid_o is combinational and equals state==FETCH && imem_ack_i && !stall_i && !halt_i && !jmp_i && !(br_i && !zero_i).
- An ack that coincides with a redirect is dropped: fetch_valid_o=0 and the wrong-path word is discarded.
- REDIRECT: lasts exactly 1 cycle. imem_req_o=0 and flush_o=1. jmp_i, br_i and halt_i are ignored. Then goes to FETCH.
- Redirect latency: redirect sampled at edge N gives new pc_o after N. Flush occupies cycle N+1. First request to the new PC is in cycle N+2.
- HALTED: imem_req_o=0 and halted_o=1. Only Reset leaves this state.
- redirect_cnt_o increments on each jump or taken branch accepted in FETCH. It saturates at all-ones.
- All address arithmetic is 32-bit and wraps without a flag. Example: 32'hFFFFFFFC + 4 = 0.
- Without the optional feature, redirect targets have bits [1:0] forced to 00. Sequential PC is always word-aligned.
- Stall has no effect on redirects: a redirect is taken even when stall_i=1.

Optional Feature:
PC_MISALIGN_TRAP_EN:
- Defined: a redirect target with bits [1:0] != 00 is not loaded. pc_o holds, the FSM goes to HALTED, and err_o=1 (sticky until reset).
- Undefined: the low bits are cleared silently and err_o is tied to 0.

Decomposition:
- Package pc_pkg: state enum (IDLE, FETCH, REDIRECT, HALTED), RESET_VEC default, PC_STEP=4, the branch bias constant 4.
- One natural sub-module, pc_next_calc: a combinational next-PC mux plus adders and the alignment check. It is instantiated once inside pc_fetch_seq.

Test Plan:
- Reset release with ack tied high → IDLE for 1 cycle, then pc_o = 0x9F0, 0x9F4, 0x9F8 with fetch_valid_o=1 each cycle.
- jmp_i at pc 0x9F8 with target 0x10 → pc_o=0xA00, flush_o=1 for 1 cycle with imem_req_o=0, then a fetch at 0xA00; redirect_cnt_o=1.
- Branch at pc 0xA00, offset 0x20, zero_i=0 → pc_o=0xA1C. The same branch with zero_i=1 → pc_o=0xA04 and no flush.
- stall_i held 3 cycles with ack high → pc_o frozen and fetch_valid_o=0. A jump during the stall is still taken.
- jmp_i and br_i taken in the same cycle → the jump wins. halt_i together with jmp_i → HALTED, pc_o unchanged, only Reset recovers. Reset asserted mid-REDIRECT → pc_o=0x9F0 immediately.
- With PC_MISALIGN_TRAP_EN, jump target 0x2 → err_o=1, halted_o=1, pc_o unchanged. Without it, pc_o=0x9F0 + 0x0.
